jk_bank_sequencer: RTL

JK_BANK_SEQUENCER -- requirements
Module: jk_bank_sequencer

---
 rtl/jk_bank_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer
//   Drives the J/K inputs of a bank of WIDTH JK flip-flops so that one
//   command is carried out per handshake. The command can be a load, a
//   set/clear/toggle mask, or a multi-step binary count up or down. The bank
//   itself (q) is modelled here and updates on every rising edge.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   cmd_valid  command present
//   cmd_ready  sequencer idle and able to accept a command
//   cmd_op     opcode (NOP, LOAD, SET, CLEAR, TOGGLE, COUNT_UP, COUNT_DOWN, reserved)
//   cmd_data   load value or bit mask
//   cmd_count  number of steps for COUNT_UP / COUNT_DOWN
//   j_out      J inputs currently driven to the bank
//   k_out      K inputs currently driven to the bank
//   q          bank state
//   busy       high while a command is being applied or completing
//   done       one-cycle completion pulse
//   err        one-cycle pulse with done when the opcode was reserved
module jk_bank_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [7:0]       cmd_count,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_LOAD   = 3'b001;
    localparam logic [2:0] OP_SET    = 3'b010;
    localparam logic [2:0] OP_CLEAR  = 3'b011;
    localparam logic [2:0] OP_TOGGLE = 3'b100;
    localparam logic [2:0] OP_UP     = 3'b101;
    localparam logic [2:0] OP_DOWN   = 3'b110;
    localparam logic [2:0] OP_RSV    = 3'b111;

    state_t           state_reg;
    logic [2:0]       op_reg;
    logic [WIDTH-1:0] data_reg;
    logic [7:0]       remaining_reg;
    logic [WIDTH-1:0] q_reg;

    // Toggle masks for a synchronous binary counter built from JK flip-flops:
    // a bit flips when every lower bit is 1 (up) or 0 (down).
    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] dn_t;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_toggle
            if (gi == 0) begin : g_lsb
                assign up_t[gi] = 1'b1;
                assign dn_t[gi] = 1'b1;
            end else begin : g_upper
                assign up_t[gi] = &q_reg[gi-1:0];
                assign dn_t[gi] = &(~q_reg[gi-1:0]);
            end
        end
    endgenerate

    wire is_count = (op_reg == OP_UP) || (op_reg == OP_DOWN);

    // J/K are only non-zero while applying; IDLE and DONE leave the bank holding.
    always_comb begin
        j_out = '0;
        k_out = '0;
        if (state_reg == ST_APPLY) begin
            unique case (op_reg)
                OP_LOAD:   begin j_out = data_reg; k_out = ~data_reg; end
                OP_SET:    begin j_out = data_reg; k_out = '0;        end
                OP_CLEAR:  begin j_out = '0;       k_out = data_reg;  end
                OP_TOGGLE: begin j_out = data_reg; k_out = data_reg;  end
                OP_UP: begin
                    // A zero step count still spends one APPLY cycle, holding q.
                    if (remaining_reg != 8'd0) begin
                        j_out = up_t;
                        k_out = up_t;
                    end
                end
                OP_DOWN: begin
                    if (remaining_reg != 8'd0) begin
                        j_out = dn_t;
                        k_out = dn_t;
                    end
                end
                OP_NOP, OP_RSV: begin
                    j_out = '0;
                    k_out = '0;
                end
                default: begin
                    j_out = '0;
                    k_out = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            op_reg        <= '0;
            data_reg      <= '0;
            remaining_reg <= '0;
            q_reg         <= '0;
        end else begin
            // JK characteristic equation, applied to every bit on every edge.
            q_reg <= (j_out & ~q_reg) | (~k_out & q_reg);

            unique case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_reg        <= cmd_op;
                        data_reg      <= cmd_data;
                        remaining_reg <= cmd_count;
                        state_reg     <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    if (is_count) begin
                        if (remaining_reg != 8'd0) begin
                            remaining_reg <= remaining_reg - 8'd1;
                        end
                        // Leave on the edge where the count reaches zero, or
                        // immediately when the command asked for zero steps.
                        if (remaining_reg <= 8'd1) begin
                            state_reg <= ST_DONE;
                        end
                    end else begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign q         = q_reg;
    assign cmd_ready = (state_reg == ST_IDLE);
    assign busy      = (state_reg == ST_APPLY) || (state_reg == ST_DONE);
    assign done      = (state_reg == ST_DONE);
    assign err       = (state_reg == ST_DONE) && (op_reg == OP_RSV);

endmodule
